// File: rtl/free_lst_pkg.sv
// free_lst_pkg
//   Shared definitions for the physical-register free list, the rename lines
//   and the TPU: register-file geometry, port count and the {vld, idx}
//   physical-register field layout carried on allocate/release buses.
package free_lst_pkg;

    localparam int PREG_NUM  = 64;            // physical registers
    localparam int PREG_BITS = 6;             // index width, log2(PREG_NUM)
    localparam int ARCH_REGS = 16;            // pre-mapped at reset, not in the list
    localparam int PORT      = 4;             // allocate/release slots per cycle

    localparam int CNT_W     = PREG_BITS + 1; // 0..PREG_NUM inclusive
    localparam int OFF_W     = 3;             // 0..PORT inclusive
    localparam int FIELD_W   = PREG_BITS + 1; // one {vld, idx} field

    // Entries held in the list straight out of reset.
    localparam int RST_CNT   = PREG_NUM - ARCH_REGS;

    typedef struct packed {
        logic                 vld;
        logic [PREG_BITS-1:0] idx;
    } preg_fld_t;

endpackage

// File: rtl/free_lst_slot_cmp.sv
// slot_cmp
//   Prefix popcount over a PORT-wide request vector. For every slot it gives
//   the number of set bits in lower-numbered slots (the slot's offset into the
//   compacted stream) and it gives the total number of set bits.
// Ports
//   vec  in   PORT-wide request/valid vector
//   off  out  per-slot exclusive prefix count
//   tot  out  popcount of vec
module slot_cmp
    import free_lst_pkg::*;
(
    input  logic [PORT-1:0]            vec,
    output logic [PORT-1:0][OFF_W-1:0] off,
    output logic [OFF_W-1:0]           tot
);

    logic [OFF_W-1:0] acc;

    always_comb begin
        acc = '0;
        off = '0;
        for (int i = 0; i < PORT; i++) begin
            off[i] = acc;
            acc    = acc + OFF_W'(vec[i]);
        end
        tot = acc;
    end

endmodule

// File: rtl/free_lst.sv
// free_lst
//   Physical-register free list: a circular FIFO of unmapped register indices.
//   Up to PORT indices are handed out per cycle (all-or-nothing) and up to PORT
//   released indices are appended per cycle; releases that do not fit are
//   dropped highest slot first and latch err_ovf.
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   alc_req        per-slot allocate request
//   alc_gnt        every requested slot is served this cycle (combinational)
//   alc_preg_flat  per-slot {vld, idx}, slot i at [FIELD_W*i +: FIELD_W]
//   rel_vld        per-slot release valid
//   rel_preg_flat  per-slot released index, slot i at [PREG_BITS*i +: PREG_BITS]
//   fre_cnt        entries in the list after the last edge
//   fre_emp        fre_cnt == 0
//   err_ovf        sticky: a release was dropped because the list was full
// Handshake: there is no back-pressure on release; allocation is offered every
// cycle and the consumer takes the indices at the edge where alc_gnt is high.
module free_lst
    import free_lst_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PORT-1:0]           alc_req,
    output logic                      alc_gnt,
    output logic [PORT*FIELD_W-1:0]   alc_preg_flat,
    input  logic [PORT-1:0]           rel_vld,
    input  logic [PORT*PREG_BITS-1:0] rel_preg_flat,
    output logic [CNT_W-1:0]          fre_cnt,
    output logic                      fre_emp,
    output logic                      err_ovf
);

    logic [PREG_BITS-1:0] mem [PREG_NUM];
    logic [PREG_BITS-1:0] head_q;
    logic [PREG_BITS-1:0] tail_q;
    logic [CNT_W-1:0]     count_q;
    logic                 err_q;

    logic [PORT-1:0][OFF_W-1:0] alc_off;
    logic [PORT-1:0][OFF_W-1:0] rel_off;
    logic [OFF_W-1:0]           alc_n;
    logic [OFF_W-1:0]           rel_m;

    slot_cmp u_alc_cmp (
        .vec (alc_req),
        .off (alc_off),
        .tot (alc_n)
    );

    slot_cmp u_rel_cmp (
        .vec (rel_vld),
        .off (rel_off),
        .tot (rel_m)
    );

    logic [CNT_W-1:0] gnt_n;    // entries actually removed this cycle
    logic [CNT_W-1:0] room;     // free space once this cycle's grant leaves
    logic [CNT_W-1:0] acc_m;    // releases actually written
    logic [PORT-1:0]  rel_acc;
    logic             rel_drop;
    preg_fld_t        fld;

    always_comb begin
        alc_gnt       = (CNT_W'(alc_n) <= count_q);
        gnt_n         = alc_gnt ? CNT_W'(alc_n) : '0;
        alc_preg_flat = '0;
        fld           = '0;
        for (int i = 0; i < PORT; i++) begin
            fld = '0;
            if (alc_gnt && alc_req[i]) begin
                fld.vld = 1'b1;
                fld.idx = mem[head_q + PREG_BITS'(alc_off[i])];
            end
            alc_preg_flat[i*FIELD_W +: FIELD_W] = fld;
        end

        // Granted entries free their slots in the same edge, so they count as
        // room for this cycle's releases.
        room     = CNT_W'(PREG_NUM) - count_q + gnt_n;
        rel_acc  = '0;
        for (int i = 0; i < PORT; i++) begin
            // Compaction order keeps the lowest slots; higher ones fall off.
            rel_acc[i] = rel_vld[i] && (CNT_W'(rel_off[i]) < room);
        end
        rel_drop = (CNT_W'(rel_m) > room);
        acc_m    = rel_drop ? room : CNT_W'(rel_m);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PREG_NUM; k++) begin
                mem[k] <= (k < RST_CNT) ? PREG_BITS'(ARCH_REGS + k) : '0;
            end
            head_q  <= '0;
            tail_q  <= PREG_BITS'(RST_CNT);
            count_q <= CNT_W'(RST_CNT);
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < PORT; i++) begin
                if (rel_acc[i]) begin
                    mem[tail_q + PREG_BITS'(rel_off[i])] <= rel_preg_flat[i*PREG_BITS +: PREG_BITS];
                end
            end
            head_q  <= head_q + PREG_BITS'(gnt_n);
            tail_q  <= tail_q + PREG_BITS'(acc_m);
            count_q <= count_q - gnt_n + acc_m;
            if (rel_drop) begin
                err_q <= 1'b1;
            end
        end
    end

    assign fre_cnt = count_q;
    assign fre_emp = (count_q == '0);
    assign err_ovf = err_q;

endmodule

// File: tb/tb_free_lst.sv
// tb_free_lst
//   Randomized and directed traffic against free_lst. A reference model (a
//   queue of free indices) predicts each cycle's allocate response and status;
//   the expectation is queued at issue and a monitor compares it with the DUT.
module tb_free_lst;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alc_req;
    logic        alc_gnt;
    logic [27:0] alc_preg_flat;
    logic [3:0]  rel_vld;
    logic [23:0] rel_preg_flat;
    logic [6:0]  fre_cnt;
    logic        fre_emp;
    logic        err_ovf;

    free_lst dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alc_req       (alc_req),
        .alc_gnt       (alc_gnt),
        .alc_preg_flat (alc_preg_flat),
        .rel_vld       (rel_vld),
        .rel_preg_flat (rel_preg_flat),
        .fre_cnt       (fre_cnt),
        .fre_emp       (fre_emp),
        .err_ovf       (err_ovf)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks incomplete");
        $fatal(1, "watchdog");
    end

    // ---------------- model state ----------------
    int   free_q[$];   // free indices in allocation order
    int   held[$];     // indices handed out and not yet released
    logic err_m;
    int   checks;
    int   errors;

    // expected word: {gnt, flat[27:0], cnt[6:0], emp, err}
    logic [37:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [23:0] pack4(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    task automatic model_reset();
        free_q.delete();
        held.delete();
        for (int k = 16; k < 64; k++) free_q.push_back(k);
        err_m = 1'b0;
    endtask

    function automatic logic [37:0] predict(input logic [3:0] req);
        int          cnt;
        int          n;
        int          r;
        logic        g;
        logic [27:0] flat;
        cnt  = free_q.size();
        n    = $countones(req);
        g    = (n <= cnt);
        flat = '0;
        r    = 0;
        for (int i = 0; i < 4; i++) begin
            if (req[i] && g) begin
                flat[7*i +: 7] = {1'b1, 6'(free_q[r])};
                r++;
            end
        end
        return {g, flat, 7'(cnt), (cnt == 0), err_m};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input logic [3:0] req, input logic [3:0] rv, input logic [23:0] rp);
        logic [37:0] e;
        int          room;
        @(negedge clk);
        alc_req       = req;
        rel_vld       = rv;
        rel_preg_flat = rp;
        e = predict(req);
        exp_q.push_back(e);
        if (e[37]) begin
            for (int k = 0; k < $countones(req); k++) held.push_back(free_q.pop_front());
        end
        room = 64 - free_q.size();
        for (int i = 0; i < 4; i++) begin
            if (rv[i]) begin
                if (room > 0) begin
                    free_q.push_back(int'(rp[6*i +: 6]));
                    room--;
                end else begin
                    err_m = 1'b1;
                end
            end
        end
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst_n         = 1'b0;
        alc_req       = '0;
        rel_vld       = '0;
        rel_preg_flat = '0;
        model_reset();
        exp_q.push_back(predict(4'b0000));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // random traffic: releases only indices previously handed out
    task automatic random_cycle();
        logic [3:0]  rv;
        logic [23:0] rp;
        int          j;
        rv = '0;
        rp = '0;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1 && held.size() > 0) begin
                j = $urandom_range(0, held.size() - 1);
                rp[6*i +: 6] = 6'(held[j]);
                held.delete(j);
                rv[i] = 1'b1;
            end
        end
        drive_cycle(4'($urandom_range(0, 15)), rv, rp);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [37:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("alc_gnt",       32'(alc_gnt),       32'(e[37]));
                chk("alc_preg_flat", 32'(alc_preg_flat), 32'(e[36:9]));
                chk("fre_cnt",       32'(fre_cnt),       32'(e[8:2]));
                chk("fre_emp",       32'(fre_emp),       32'(e[1]));
                chk("err_ovf",       32'(err_ovf),       32'(e[0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        alc_req       = '0;
        rel_vld       = '0;
        rel_preg_flat = '0;
        model_reset();

        // reset state, then full-width allocation: 16..19
        reset_cycle();
        drive_cycle(4'b1111, 4'b0000, '0);
        drive_cycle(4'b0000, 4'b0000, '0);

        // sparse request: slot1=16, slot3=17
        reset_cycle();
        drive_cycle(4'b1010, 4'b0000, '0);

        // drain 46 -> 2, refuse 3, grant 2
        for (int k = 0; k < 11; k++) drive_cycle(4'b1111, 4'b0000, '0);
        drive_cycle(4'b0111, 4'b0000, '0);
        drive_cycle(4'b0011, 4'b0000, '0);

        // empty: release 5 and 9 with a request -> refused; next cycle they come out
        drive_cycle(4'b0001, 4'b0011, pack4(5, 9, 0, 0));
        drive_cycle(4'b0011, 4'b0000, '0);

        // long random traffic, heads and tails wrap many times
        for (int k = 0; k < 600; k++) random_cycle();

        // fill to 64 by returning the pre-mapped registers
        reset_cycle();
        for (int b = 0; b < 4; b++) drive_cycle(4'b0000, 4'b1111, pack4(4*b, 4*b+1, 4*b+2, 4*b+3));
        drive_cycle(4'b0000, 4'b0000, '0);
        // full: single release is dropped
        drive_cycle(4'b0000, 4'b0001, pack4(3, 0, 0, 0));
        // full with 2 granted: slots 0,1 accepted, slots 2,3 dropped
        drive_cycle(4'b0011, 4'b1111, pack4(40, 41, 42, 43));
        drive_cycle(4'b0000, 4'b0000, '0);
        for (int k = 0; k < 20; k++) random_cycle();

        // reset in the middle of traffic
        reset_cycle();
        drive_cycle(4'b0001, 4'b0000, '0);
        for (int k = 0; k < 40; k++) random_cycle();

        @(negedge clk);
        #5;
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/free_lst.md
# free_lst

Physical-register free list for the rename path. It holds every unmapped physical register index in a circular FIFO and hands out up to PORT indices per cycle to the rename lines as pdest values. It takes back up to PORT indices per cycle as the renamer releases old mappings (the per-line fre_preg values). It sits beside the rename/TPU matrix: its allocate output feeds the pdest field, and its release input consumes the freed-register outputs.

## Interface
- PREG_NUM, 64, number of physical registers
- PREG_BITS, 6, index width (log2 PREG_NUM)
- ARCH_REGS, 16, registers pre-mapped at reset (indices 0..ARCH_REGS-1, never in the list at reset)
- PORT, 4, allocate/release ports per cycle

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alc_req  in  PORT  per-slot allocate request; any bit pattern is legal
- alc_gnt  out  1  all requested slots served this cycle (combinational)
- alc_preg_flat  out  PORT*(PREG_BITS+1)  per slot {vld, idx}; slot i occupies bits [7i+6:7i]
- rel_vld  in  PORT  per-slot release valid
- rel_preg_flat  in  PORT*PREG_BITS  released index; slot i occupies bits [6i+5:6i]
- fre_cnt  out  PREG_BITS+1  entries currently in list (registered)
- fre_emp  out  1  fre_cnt == 0
- err_ovf  out  1  sticky; a release was dropped because the list was full

## Operation
- Storage: PREG_NUM x PREG_BITS array, head pointer, tail pointer (PREG_BITS wide, wrap mod PREG_NUM), count register (PREG_BITS+1 wide).
- Reset: entry k = ARCH_REGS+k for k < PREG_NUM-ARCH_REGS; head=0; tail=48; count=48; err_ovf=0.
- Allocate:
  - n = popcount(alc_req).
  - alc_gnt = (n <= count); n = 0 gives alc_gnt=1.
  - When granted, each requested slot i receives entry head+r, where r is the number of set request bits below i.
  - Granted slots have vld=1. Unrequested slots have vld=0, idx=0.
  - On refusal, all vld=0 and the list is unchanged. Allocation is all-or-nothing.
- Release:
  - Valid release slots are compacted in ascending slot order and written at tail, tail+1, …
  - m = popcount(rel_vld).
  - Released entries become allocatable the next cycle, never the same cycle.
- Update at clk edge: head += granted n; tail += accepted m; count = count - granted n + accepted m.
- Overflow: accepted m = min(m, PREG_NUM - count + granted n). Excess slots, highest-numbered first, are dropped and set err_ovf. err_ovf clears only on reset.
- The list does not check indices; releasing an index twice is the caller's error and is not detected.

## Timing
- Allocate path is combinational from registered head/count to alc_gnt/alc_preg_flat, with zero-cycle latency. The consumer samples at the same edge that advances head.
- Release-to-allocatable latency is 1 cycle.
- fre_cnt/fre_emp reflect the state after the last edge; they do not include the current cycle's requests.
- Simultaneous allocate and release at count 0 refuses any n>0; released indices are available next cycle.
- Wrap-around: pointers roll 63 -> 0 silently. Full is count == PREG_NUM, and then head == tail.
- Asynchronous reset mid-operation restores the reset contents immediately. alc_gnt then re-evaluates against count=48.

## Structure
- Shared package: PREG_NUM, PREG_BITS, ARCH_REGS, PORT, and the {vld, idx} preg field layout. This package is shared with the rename lines and TPU.
- One sub-module, slot_cmp: a PORT-wide prefix popcount that yields per-slot offsets and the total. It is instantiated twice, once for alc_req and once for rel_vld.
- The array is plain flops with PORT write ports and PORT combinational read ports.

## Test plan
- Reset, then alc_req=4'b1111 -> alc_gnt=1; slots give 16,17,18,19; next cycle fre_cnt=44.
- After reset, alc_req=4'b1010 -> slot1=16, slot3=17, slots 0/2 vld=0; fre_cnt=46.
- Drain to fre_cnt=2, then alc_req=4'b0111 -> alc_gnt=0, all vld=0, fre_cnt stays 2. Next, alc_req=4'b0011 in the same state -> granted.
- At fre_cnt=0, release 5 and 9 while alc_req=4'b0001 -> alc_gnt=0. Next cycle alc_req=4'b0011 -> 5, 9.
- Cycle allocations/releases until head passes 63 -> indices continue from entry 0 in FIFO order, and fre_cnt stays consistent.
- With list full (count 64), release 1 valid index -> dropped, err_ovf=1 and stays set. Then assert rst_n=0 mid-traffic -> fre_cnt=48, err_ovf=0, first allocation returns 16.
